// File: rtl/adder_mw_seq.sv
// adder: 16-bit Kogge-Stone parallel-prefix adder.
//   a, b  : 16-bit addends
//   cin   : carry in
//   sum   : 16-bit result
//   cout  : carry out of bit 15
//
// adder_mw_seq: multi-word add/subtract sequencer. Operands of WORDS x 16 bits
// are captured on a valid/ready handshake and pushed limb-by-limb (LSB first)
// through a single adder instance, with the limb carry held in a register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake
//   in_a, in_b            : W-bit operands
//   in_cin                : carry-in (add) or active-high borrow-in (subtract)
//   in_sub                : 0 = A+B+cin, 1 = A-B-borrow
//   out_valid / out_ready : result handshake
//   out_sum               : W-bit result
//   out_cout              : carry-out (add) or active-high borrow-out (subtract)
//   out_ovf               : two's-complement signed overflow of the W-bit op

module adder (
    output logic        cout,
    output logic [15:0] sum,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin
);
    logic [15:0] h;
    logic [15:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4;

    // One prefix level: combine each bit's (g,p) with the group d bits below.
    function automatic logic [31:0] ks_level(input logic [15:0] g,
                                             input logic [15:0] p,
                                             input int d);
        logic [15:0] gn, pn;
        gn = g;
        pn = p;
        for (int i = 0; i < 16; i++) begin
            if (i >= d) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
        end
        return {gn, pn};
    endfunction

    always_comb begin
        h  = a ^ b;
        g0 = a & b;
        p0 = h;
        // Fold cin into bit 0 so the prefix tree yields carries directly.
        g0[0] = (a[0] & b[0]) | (h[0] & cin);
    end

    assign {g1, p1} = ks_level(g0, p0, 1);
    assign {g2, p2} = ks_level(g1, p1, 2);
    assign {g3, p3} = ks_level(g2, p2, 4);
    assign {g4, p4} = ks_level(g3, p3, 8);

    assign sum  = h ^ {g4[14:0], cin};
    assign cout = g4[15];
endmodule

// FSM states
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   RUN   | one limb per cycle through the adder
//   DONE  | result presented, held until out_ready
module adder_mw_seq #(
    parameter  int WORDS = 4,
    localparam int W     = 16 * WORDS,
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          carry_q;
    logic [W-1:0]  a_q, b_q;
    logic          sub_q;

    logic          accept;
    logic          last_limb;
    logic [15:0]   add_a, add_b, add_sum;
    logic          add_cout;
    logic          c15;

    assign last_limb = (cnt_q == CW'(WORDS - 1));
    assign add_a     = a_q[{cnt_q, 4'b0000} +: 16];
    assign add_b     = b_q[{cnt_q, 4'b0000} +: 16];
    // Carry into the top bit of the last limb, needed for signed overflow.
    assign c15       = add_a[15] ^ add_b[15] ^ add_sum[15];

    adder u_adder (
        .cout (add_cout),
        .sum  (add_sum),
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Hold in_ready low while reset is asserted.
                in_ready = rst_n;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_limb) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + ~borrow.
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            sub_q   <= in_sub;
            carry_q <= in_sub ? ~in_cin : in_cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            out_sum[{cnt_q, 4'b0000} +: 16] <= add_sum;
            carry_q <= add_cout;
            if (last_limb) begin
                out_cout <= sub_q ? ~add_cout : add_cout;
                out_ovf  <= c15 ^ add_cout;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adder_mw_seq.sv
module tb_adder_mw_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_cin, in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout, out_ovf;

    int vectors     = 0;
    int miscompares = 0;

    adder_mw_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain wide integer arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W:0] full;
        logic       ovf;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            // Negative true result wraps, so bit W is the borrow.
            full = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
            ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end
        return {ovf, full[W], full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) until it is accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        check("accept_timeout", W'(n < 50), W'(1));
        step();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid; returns number of edges after acceptance.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin step(); lat++; end
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] exp);
        check({tag, "_sum"},  out_sum, exp[W-1:0]);
        check({tag, "_cout"}, W'(out_cout), W'(exp[W]));
        check({tag, "_ovf"},  W'(out_ovf),  W'(exp[W+1]));
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        int lat;
        issue(a, b, cin, sub);
        wait_result(lat);
        check({tag, "_latency"}, W'(lat), W'(WORDS));
        check_result(tag, model(a, b, cin, sub));
        handshake();
        check({tag, "_idle_ready"}, W'({in_ready, out_valid}), W'(2'b10));
    endtask

    initial begin
        logic [W+1:0] exp;
        logic [W-1:0] ra, rb;
        int           lat;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_outs", {out_sum[W-1:4], out_cout, out_ovf, out_valid, in_ready}, '0);
        #20;
        rst_n = 1'b1;
        step();
        check("rst_ready", W'(in_ready), W'(1));

        run_op("all_ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        check("all_ones_sum_literal", out_sum, 64'h0);
        run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        check("pos_ovf_literal", {out_sum[W-1:1], out_ovf}, {63'h4000_0000_0000_0000, 1'b1});
        run_op("limb_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        check("limb_chain_literal", out_sum, 64'h0000_0000_0001_0000);
        run_op("sub_0_1", 64'h0, 64'h1, 1'b0, 1'b1);
        check("sub_0_1_borrow", W'(out_cout), W'(1));
        run_op("sub_min_1", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
        check("sub_min_1_literal", out_sum, 64'h7FFF_FFFF_FFFF_FFFF);
        run_op("add_cin", 64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        run_op("sub_bin", 64'h5, 64'h5, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 6 == 1) rb = ~ra;
            if (i % 6 == 3) rb = ra;
            run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
        end

        // Backpressure: hold result, new request must not be taken.
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        issue(ra, rb, 1'b0, 1'b1);
        wait_result(lat);
        check("bp_latency", W'(lat), W'(WORDS));
        exp = model(ra, rb, 1'b0, 1'b1);
        in_a = 64'h1234; in_b = 64'h1111; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_result("bp_hold", exp);
            check("bp_flags", W'({out_valid, in_ready}), W'(2'b10));
            step();
        end
        handshake();
        check("bp_release", W'({out_valid, in_ready}), W'(2'b01));
        step();
        in_valid = 1'b0;
        check("bp_taken", W'(in_ready), W'(0));
        wait_result(lat);
        check("bp_held_latency", W'(lat), W'(WORDS));
        check_result("bp_held", model(64'h1234, 64'h1111, 1'b1, 1'b0));
        handshake();

        // Asynchronous reset in the 2nd RUN cycle.
        issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outs", {out_sum[W-1:4], out_cout, out_ovf, out_valid, in_ready}, '0);
        #3;
        rst_n = 1'b1;
        step();
        check("abort_ready", W'(in_ready), W'(1));
        run_op("after_abort", 64'h3, 64'h4, 1'b0, 1'b0);
        check("after_abort_literal", out_sum, 64'h7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
